// File: rtl/lsq_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lsq_issue_arbiter
//  Purpose  : Consumer end of the load/store queue. Picks the head load or
//             store, pops it, dispatches it one-hot to a memory subunit, and
//             tracks outstanding loads so returned words are aligned,
//             sign/zero-extended and written back in issue order.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                  clock, synchronous active-high reset
//    load_*   / load_pop       head load request and its accept strobe
//    store_*  / store_pop      head store request and its accept strobe
//    sub_ready                 per-subunit accept capability
//    sub_req, req_*            one-hot request strobe and muxed payload
//    sub_rvalid, sub_rdata     per-subunit load return (subunit i at [32i+:32])
//    wb_valid/id/data/done     registered in-order load writeback
//    idle                      no outstanding loads
// ============================================================================
module lsq_issue_arbiter #(
    parameter  int NUM_SUBUNITS    = 3,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int ID_W            = 3,
    localparam int SUB_W           = (NUM_SUBUNITS > 1) ? $clog2(NUM_SUBUNITS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    input  logic [31:0]               load_addr,
    input  logic [2:0]                load_fn3,
    input  logic [ID_W-1:0]           load_id,
    input  logic [SUB_W-1:0]          load_subunit,
    input  logic                      load_hold,
    output logic                      load_pop,
    input  logic                      store_valid,
    input  logic [31:0]               store_addr,
    input  logic [3:0]                store_be,
    input  logic [31:0]               store_data,
    input  logic [SUB_W-1:0]          store_subunit,
    output logic                      store_pop,
    input  logic [NUM_SUBUNITS-1:0]   sub_ready,
    output logic [NUM_SUBUNITS-1:0]   sub_req,
    output logic [31:0]               req_addr,
    output logic                      req_rnw,
    output logic [3:0]                req_be,
    output logic [31:0]               req_data,
    input  logic [NUM_SUBUNITS-1:0]   sub_rvalid,
    input  logic [32*NUM_SUBUNITS-1:0] sub_rdata,
    output logic                      wb_valid,
    output logic [ID_W-1:0]           wb_id,
    output logic [31:0]               wb_data,
    output logic                      wb_done,
    output logic                      idle
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W:0] c_max_count = (PTR_W+1)'(MAX_OUTSTANDING);

    // Load tracker: circular buffer of issued loads awaiting data
    logic [ID_W-1:0]  r_trk_id   [MAX_OUTSTANDING];
    logic [SUB_W-1:0] r_trk_sub  [MAX_OUTSTANDING];
    logic             r_trk_hold [MAX_OUTSTANDING];
    logic [2:0]       r_trk_fn3  [MAX_OUTSTANDING];
    logic [1:0]       r_trk_off  [MAX_OUTSTANDING];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_ld_ready;
    logic             w_st_ready;
    logic             w_ld_go;
    logic             w_st_go;
    logic [SUB_W-1:0] w_tail_sub;
    logic [SUB_W-1:0] w_sel_sub;
    logic             w_head_rvalid;
    logic [31:0]      w_head_rdata;
    logic             w_rsp;
    logic [31:0]      w_shifted;
    logic [31:0]      w_ext;

    // Subunit of the most recently issued load; all outstanding loads share it
    assign w_tail_sub = r_trk_sub[r_tail - 1'b1];

    // Range-safe lookup of the ready bits for the requested subunits
    always_comb begin
        w_ld_ready = 1'b0;
        w_st_ready = 1'b0;
        for (int i = 0; i < NUM_SUBUNITS; i++) begin
            if (load_subunit == SUB_W'(i))  w_ld_ready = sub_ready[i];
            if (store_subunit == SUB_W'(i)) w_st_ready = sub_ready[i];
        end
    end

    // Loads may only chain onto the subunit already in flight so that returns
    // from a single subunit arrive in issue order. A response arriving while
    // full does not free a slot until the following cycle.
    assign w_ld_go = ~rst & load_valid & w_ld_ready & (r_count < c_max_count)
                   & ((r_count == '0) | (load_subunit == w_tail_sub));
    assign w_st_go = ~rst & store_valid & ~w_ld_go & w_st_ready;

    assign load_pop  = w_ld_go;
    assign store_pop = w_st_go;
    assign w_sel_sub = w_ld_go ? load_subunit : store_subunit;

    always_comb begin
        sub_req = '0;
        for (int i = 0; i < NUM_SUBUNITS; i++) begin
            if ((w_ld_go | w_st_go) && (w_sel_sub == SUB_W'(i))) sub_req[i] = 1'b1;
        end
    end

    assign req_addr = w_ld_go ? load_addr : (w_st_go ? store_addr : 32'h0);
    assign req_rnw  = w_ld_go;
    assign req_be   = w_ld_go ? 4'hF : (w_st_go ? store_be : 4'h0);
    assign req_data = w_st_go ? store_data : 32'h0;

    // Return path is only watched on the head entry's subunit
    always_comb begin
        w_head_rvalid = 1'b0;
        w_head_rdata  = 32'h0;
        for (int i = 0; i < NUM_SUBUNITS; i++) begin
            if (r_trk_sub[r_head] == SUB_W'(i)) begin
                w_head_rvalid = sub_rvalid[i];
                w_head_rdata  = sub_rdata[32*i +: 32];
            end
        end
    end

    assign w_rsp = ~rst & (r_count != '0) & w_head_rvalid;

    // Align the addressed byte/half to bit 0, then extend per fn3
    assign w_shifted = w_head_rdata >> {r_trk_off[r_head], 3'b000};

    always_comb begin
        case (r_trk_fn3[r_head])
            3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ext = {24'h0, w_shifted[7:0]};
            3'b101:  w_ext = {16'h0, w_shifted[15:0]};
            default: w_ext = w_shifted;
        endcase
    end

    // Tracker payload needs no reset: validity is defined by the pointers
    always_ff @(posedge clk) begin
        if (w_ld_go) begin
            r_trk_id[r_tail]   <= load_id;
            r_trk_sub[r_tail]  <= load_subunit;
            r_trk_hold[r_tail] <= load_hold;
            r_trk_fn3[r_tail]  <= load_fn3;
            r_trk_off[r_tail]  <= load_addr[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_ld_go) r_tail <= r_tail + 1'b1;
            if (w_rsp)   r_head <= r_head + 1'b1;
            r_count <= r_count + {{PTR_W{1'b0}}, w_ld_go} - {{PTR_W{1'b0}}, w_rsp};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_id    <= '0;
            wb_data  <= 32'h0;
            wb_done  <= 1'b0;
        end else begin
            wb_valid <= w_rsp;
            wb_done  <= w_rsp & ~r_trk_hold[r_head];
            if (w_rsp) begin
                wb_id   <= r_trk_id[r_head];
                wb_data <= w_ext;
            end
        end
    end

    assign idle = (r_count == '0);

    // A return is legal only from the head entry's subunit with loads pending
    a_rvalid_legal : assert property (@(posedge clk) disable iff (rst)
        (|sub_rvalid) |-> ((r_count != '0) &&
                           ((sub_rvalid & ~(NUM_SUBUNITS'(1) << r_trk_sub[r_head])) == '0)));

endmodule
`default_nettype wire

// File: tb/tb_lsq_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsq_issue_arbiter
//  Purpose  : Self-checking bench for lsq_issue_arbiter. Directed scenarios
//             followed by randomized traffic, all compared against a
//             queue-based behavioural model of the load tracker.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsq_issue_arbiter;

    localparam int NS   = 3;
    localparam int MAXO = 4;
    localparam int ID_W = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [31:0]   load_addr;
    logic [2:0]    load_fn3;
    logic [ID_W-1:0] load_id;
    logic [1:0]    load_subunit;
    logic          load_hold;
    logic          load_pop;
    logic          store_valid;
    logic [31:0]   store_addr;
    logic [3:0]    store_be;
    logic [31:0]   store_data;
    logic [1:0]    store_subunit;
    logic          store_pop;
    logic [NS-1:0] sub_ready;
    logic [NS-1:0] sub_req;
    logic [31:0]   req_addr;
    logic          req_rnw;
    logic [3:0]    req_be;
    logic [31:0]   req_data;
    logic [NS-1:0] sub_rvalid;
    logic [32*NS-1:0] sub_rdata;
    logic          wb_valid;
    logic [ID_W-1:0] wb_id;
    logic [31:0]   wb_data;
    logic          wb_done;
    logic          idle;

    always #5 clk = ~clk;

    lsq_issue_arbiter #(.NUM_SUBUNITS(NS), .MAX_OUTSTANDING(MAXO), .ID_W(ID_W)) u_dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_addr(load_addr), .load_fn3(load_fn3),
        .load_id(load_id), .load_subunit(load_subunit), .load_hold(load_hold),
        .load_pop(load_pop),
        .store_valid(store_valid), .store_addr(store_addr), .store_be(store_be),
        .store_data(store_data), .store_subunit(store_subunit), .store_pop(store_pop),
        .sub_ready(sub_ready), .sub_req(sub_req), .req_addr(req_addr),
        .req_rnw(req_rnw), .req_be(req_be), .req_data(req_data),
        .sub_rvalid(sub_rvalid), .sub_rdata(sub_rdata),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_done(wb_done),
        .idle(idle)
    );

    typedef struct {
        int unsigned id;
        int unsigned sub;
        bit          hold;
        int unsigned fn3;
        int unsigned off;
    } pend_t;

    pend_t       q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          e_wb_valid;
    int unsigned e_wb_id;
    int unsigned e_wb_data;
    bit          e_wb_done;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Memory-style load semantics: pick the addressed byte/half, then extend
    function automatic int unsigned load_result(int unsigned fn3, int unsigned off, int unsigned word);
        int unsigned v;
        v = word >> (8 * off);
        case (fn3)
            0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
            1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
            4: v = v % 256;
            5: v = v % 65536;
            default: ;
        endcase
        return v;
    endfunction

    task automatic clear_inputs();
        load_valid = 0; load_addr = 0; load_fn3 = 3'd2; load_id = 0;
        load_subunit = 0; load_hold = 0;
        store_valid = 0; store_addr = 0; store_be = 0; store_data = 0; store_subunit = 0;
        sub_ready = '1; sub_rvalid = '0; sub_rdata = '0;
    endtask

    // Inputs are set by the caller just after a rising edge. Checks the
    // combinational request side mid-cycle, clocks, then checks writeback.
    task automatic run_cycle();
        bit          e_ld, e_st, rsp;
        int unsigned sel;
        logic [NS-1:0] e_req;
        pend_t       p;
        #2;
        e_ld = 0; e_st = 0; e_req = '0; rsp = 0;
        if (!rst) begin
            e_ld = load_valid && load_subunit < NS && sub_ready[load_subunit]
                && q.size() < MAXO && (q.size() == 0 || q[$].sub == load_subunit);
            e_st = store_valid && !e_ld && store_subunit < NS && sub_ready[store_subunit];
            rsp  = q.size() > 0 && sub_rvalid[q[0].sub];
        end
        sel = e_ld ? load_subunit : store_subunit;
        if (e_ld || e_st) e_req = NS'(1 << sel);
        check("load_pop", 32'(load_pop), 32'(e_ld));
        check("store_pop", 32'(store_pop), 32'(e_st));
        check("sub_req", 32'(sub_req), 32'(e_req));
        check("req_rnw", 32'(req_rnw), 32'(e_ld));
        if (e_ld) begin
            check("req_addr_ld", req_addr, load_addr);
            check("req_be_ld", 32'(req_be), 32'hF);
        end
        if (e_st) begin
            check("req_addr_st", req_addr, store_addr);
            check("req_be_st", 32'(req_be), 32'(store_be));
            check("req_data_st", req_data, store_data);
        end
        if (rst) begin
            q.delete();
            e_wb_valid = 0; e_wb_id = 0; e_wb_data = 0; e_wb_done = 0;
        end else begin
            e_wb_valid = rsp;
            if (rsp) begin
                p = q.pop_front();
                e_wb_id   = p.id;
                e_wb_data = load_result(p.fn3, p.off, sub_rdata[32*p.sub +: 32]);
                e_wb_done = !p.hold;
            end
            if (e_ld) q.push_back('{load_id, load_subunit, load_hold, load_fn3, load_addr[1:0]});
        end
        @(posedge clk);
        #1;
        check("wb_valid", 32'(wb_valid), 32'(e_wb_valid));
        check("idle", 32'(idle), 32'(q.size() == 0));
        if (e_wb_valid || rst) begin
            check("wb_id", 32'(wb_id), e_wb_id);
            check("wb_data", wb_data, e_wb_data);
            check("wb_done", 32'(wb_done), 32'(e_wb_done));
        end
    endtask

    // Issue one load on an idle tracker, return the word, check the result
    task automatic do_load(input int id, input logic [31:0] addr, input int fn3,
                           input int sub, input logic [31:0] word, input logic [31:0] exp);
        clear_inputs();
        load_valid = 1; load_id = ID_W'(id); load_addr = addr;
        load_fn3 = 3'(fn3); load_subunit = 2'(sub);
        run_cycle();
        clear_inputs();
        sub_rvalid[sub] = 1'b1;
        sub_rdata[32*sub +: 32] = word;
        run_cycle();
        check("wb_data_directed", wb_data, exp);
        clear_inputs();
    endtask

    initial begin
        int unsigned r;
        int unsigned fns[5];
        fns = '{0, 1, 2, 4, 5};
        clear_inputs();
        rst = 1;
        run_cycle();
        run_cycle();
        rst = 0;

        // Basic word load and alignment/extension cases
        do_load(2, 32'h100, 2, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        check("wb_done_lw", 32'(wb_done), 32'h1);
        do_load(1, 32'h103, 0, 1, 32'h80FFFFFF, 32'hFFFFFF80);
        do_load(1, 32'h103, 4, 1, 32'h80FFFFFF, 32'h00000080);
        do_load(3, 32'h102, 5, 2, 32'h1234ABCD, 32'h00001234);
        do_load(4, 32'h102, 1, 2, 32'h8234ABCD, 32'hFFFF8234);

        // Load wins over store; blocked load lets store through
        load_valid = 1; load_subunit = 0; load_addr = 32'h40;
        store_valid = 1; store_subunit = 1; store_addr = 32'h80; store_be = 4'h3; store_data = 32'h5A5A;
        run_cycle();
        load_valid = 0; sub_rvalid[0] = 1; sub_rdata[31:0] = 32'h11;
        store_valid = 0;
        run_cycle();
        clear_inputs();
        load_valid = 1; load_subunit = 0; sub_ready = 3'b010;
        store_valid = 1; store_subunit = 1; store_addr = 32'h84; store_be = 4'hC; store_data = 32'hCAFE;
        run_cycle();
        check("store_onehot", 32'(sub_req), 32'h2);
        clear_inputs();

        // Fill tracker on subunit 1, fifth load waits for a return
        load_valid = 1; load_subunit = 1; load_fn3 = 3'd2;
        for (int i = 0; i < 5; i++) begin
            load_id = ID_W'(i);
            run_cycle();
            if (load_pop) load_id = ID_W'(i + 1);
        end
        check("full_block", 32'(load_pop), 32'h0);
        load_id = 4;
        sub_rvalid[1] = 1; sub_rdata[63:32] = 32'hA0;
        run_cycle();
        sub_rvalid = '0;
        run_cycle();
        load_valid = 0;
        for (int i = 0; i < 4; i++) begin
            sub_rvalid[1] = 1; sub_rdata[63:32] = 32'hB0 + 32'(i);
            run_cycle();
            check("inorder_id", 32'(wb_id), 32'(i + 1));
        end
        clear_inputs();

        // Subunit switch waits for the tracker to drain
        load_valid = 1; load_subunit = 0; load_id = 6;
        run_cycle();
        load_subunit = 2; load_id = 7;
        run_cycle();
        run_cycle();
        sub_rvalid[0] = 1; sub_rdata[31:0] = 32'h77;
        run_cycle();
        sub_rvalid = '0;
        run_cycle();
        load_valid = 0;
        sub_rvalid[2] = 1; sub_rdata[95:64] = 32'h99;
        run_cycle();
        clear_inputs();

        // Split double load, then reset with two loads outstanding
        load_valid = 1; load_subunit = 1; load_id = 5; load_hold = 1;
        run_cycle();
        load_hold = 0; load_addr = 32'h4;
        run_cycle();
        load_valid = 0; sub_rvalid[1] = 1; sub_rdata[63:32] = 32'h1;
        run_cycle();
        check("split_first_done", 32'(wb_done), 32'h0);
        sub_rdata[63:32] = 32'h2;
        run_cycle();
        check("split_second_done", 32'(wb_done), 32'h1);
        clear_inputs();
        load_valid = 1; load_subunit = 2;
        run_cycle();
        run_cycle();
        clear_inputs();
        rst = 1;
        run_cycle();
        rst = 0;
        check("reset_idle", 32'(idle), 32'h1);
        check("reset_wb_valid", 32'(wb_valid), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 99);
            rst = (r == 0);
            load_valid = ($urandom_range(0, 99) < 60);
            if (q.size() > 0 && $urandom_range(0, 9) < 7) load_subunit = 2'(q[$].sub);
            else load_subunit = 2'($urandom_range(0, NS - 1));
            load_fn3 = 3'(fns[$urandom_range(0, 4)]);
            load_addr = $urandom;
            if (load_fn3 == 3'd2) load_addr[1:0] = 2'b00;
            else if (load_fn3 == 3'd1 || load_fn3 == 3'd5) load_addr[0] = 1'b0;
            load_id = ID_W'($urandom);
            load_hold = ($urandom_range(0, 3) == 0);
            store_valid = ($urandom_range(0, 1) == 1);
            store_subunit = 2'($urandom_range(0, NS - 1));
            store_addr = $urandom; store_be = 4'($urandom); store_data = $urandom;
            sub_ready = NS'($urandom);
            sub_rdata = {$urandom, $urandom, $urandom};
            sub_rvalid = '0;
            if (!rst && q.size() > 0 && $urandom_range(0, 1) == 1) sub_rvalid[q[0].sub] = 1'b1;
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
